// File: rtl/uart_fifo_tx_if.sv
// Bus between the UART transmitter and its byte FIFO, plus the serial line and status.
//   fifo_dout   : byte at FIFO read head          (FIFO -> TX)
//   fifo_empty  : FIFO holds no data               (FIFO -> TX)
//   fifo_rd_en  : one-cycle pop request            (TX -> FIFO)
//   serial_out  : UART TX line, idle high          (TX -> line)
//   busy        : transmitter not idle             (TX -> system)
// Modports: master = transmitter side, slave = FIFO/system side.
interface uart_fifo_tx_if;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       serial_out;
  logic       busy;

  modport master (
    input  fifo_dout,
    input  fifo_empty,
    output fifo_rd_en,
    output serial_out,
    output busy
  );

  modport slave (
    output fifo_dout,
    output fifo_empty,
    input  fifo_rd_en,
    input  serial_out,
    input  busy
  );
endinterface

// File: rtl/uart_fifo_tx.sv
// UART transmitter that drains a byte FIFO: 8N1 frames, LSB first, idle-high line.
// Ports:
//   clk   : sole clock, rising edge
//   rst   : synchronous active-high reset
//   tx_if : uart_fifo_tx_if.master (fifo_dout/fifo_empty in, fifo_rd_en/serial_out/busy out)
// Parameters: CLOCK_FREQ (Hz), BAUD_RATE (bit/s); one symbol = CLOCK_FREQ/BAUD_RATE cycles.
// Optional feature: define UART_FIFO_TX_PARITY_EN to insert an even-parity bit after the data.
// fifo_rd_en is a combinational decode (IDLE and FIFO non-empty); all other outputs are registered.
module uart_fifo_tx #(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic             clk,
  input  logic             rst,
  uart_fifo_tx_if.master   tx_if
);

  localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef UART_FIFO_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             serial_out_q;
  logic             busy_q;
`ifdef UART_FIFO_TX_PARITY_EN
  logic             parity_q;
`endif

  logic baud_last;
  assign baud_last = (baud_q == BAUD_LAST);

  // Pop request: only in IDLE with data available, and never while in reset.
  assign tx_if.fifo_rd_en = (state_q == IDLE) && !tx_if.fifo_empty && !rst;
  assign tx_if.serial_out = serial_out_q;
  assign tx_if.busy       = busy_q;

  // Frame sequencer; serial_out_q is loaded with the level of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      serial_out_q <= 1'b1;
      busy_q       <= 1'b0;
`ifdef UART_FIFO_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!tx_if.fifo_empty) begin
            state_q <= POP;
            busy_q  <= 1'b1;
          end
        end
        POP: state_q <= LOAD;
        LOAD: begin
          shift_q      <= tx_if.fifo_dout;
          baud_q       <= '0;
          bit_q        <= '0;
          serial_out_q <= 1'b0;
          state_q      <= START;
`ifdef UART_FIFO_TX_PARITY_EN
          parity_q     <= ^tx_if.fifo_dout;
`endif
        end
        START: begin
          if (baud_last) begin
            baud_q       <= '0;
            serial_out_q <= shift_q[0];
            state_q      <= DATA;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_FIFO_TX_PARITY_EN
              serial_out_q <= parity_q;
              state_q      <= PARITY;
`else
              serial_out_q <= 1'b1;
              state_q      <= STOP;
`endif
            end else begin
              // Next data bit is shift_q[1] before the shift lands.
              bit_q        <= bit_q + 3'd1;
              shift_q      <= {1'b0, shift_q[7:1]};
              serial_out_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
`ifdef UART_FIFO_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_q       <= '0;
            serial_out_q <= 1'b1;
            state_q      <= STOP;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (baud_last) begin
            baud_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        default: begin
          state_q      <= IDLE;
          serial_out_q <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx at default parameters (1085 cycles per symbol).
module tb_uart_fifo_tx;

  localparam int SET = 125_000_000 / 115_200;
`ifdef UART_FIFO_TX_PARITY_EN
  localparam int NSYM = 11;
`else
  localparam int NSYM = 10;
`endif
  localparam int LIMIT = 4 * NSYM * SET;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  uart_fifo_tx_if tif ();

  uart_fifo_tx dut (
    .clk   (clk),
    .rst   (rst),
    .tx_if (tif.master)
  );

  // FIFO model: standard-read FIFO, popped byte appears on dout after the rd_en edge.
  logic [7:0] q[$];
  logic [7:0] dout_r = 8'h00;
  int         qn = 0;
  logic       push_v = 1'b0;
  logic [7:0] push_b = 8'h00;
  logic       tog_en = 1'b0;
  logic       tog_v = 1'b1;

  assign tif.fifo_dout  = dout_r;
  assign tif.fifo_empty = tog_en ? tog_v : (qn == 0);

  always @(posedge clk) begin
    if (push_v) q.push_back(push_b);
    if (tif.fifo_rd_en === 1'b1 && q.size() > 0) begin
      dout_r <= q[0];
      void'(q.pop_front());
    end
    qn <= q.size();
  end

  always @(negedge clk) begin
    if (tog_en) tog_v <= 1'($urandom_range(0, 1));
  end

  // rd_en protocol monitor.
  int   cyc = 0;
  int   rd_cnt = 0;
  int   rd_cyc = 0;
  int   viol = 0;
  logic prev_rd = 1'b0;
  always @(posedge clk) begin
    if (tif.fifo_rd_en === 1'b1) begin
      rd_cnt = rd_cnt + 1;
      rd_cyc = cyc;
      if (tif.fifo_empty !== 1'b0 || prev_rd || rst) viol = viol + 1;
    end
    prev_rd = (tif.fifo_rd_en === 1'b1);
    cyc = cyc + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] b);
    push_b = b;
    push_v = 1'b1;
    @(negedge clk);
    push_v = 1'b0;
  endtask

  function automatic logic exp_sym(input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
`ifdef UART_FIFO_TX_PARITY_EN
    if (s == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Wait (bounded) for the start bit; returns number of high cycles seen first.
  task automatic wait_start(output int n, output bit found);
    n = 0;
    while (tif.serial_out !== 1'b0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    found = (tif.serial_out === 1'b0);
    chk("start_found", 32'(found), 32'd1);
  endtask

  // Check every symbol on its first and last cycle; returns at the first idle cycle.
  task automatic check_frame(input logic [7:0] b, input int exp_gap, input bit tog);
    int n;
    bit found;
    int rd0;
    wait_start(n, found);
    if (!found) return;
    if (exp_gap >= 0) chk("gap", 32'(n), 32'(exp_gap));
    chk("busy_in_frame", 32'(tif.busy), 32'd1);
    if (tog) tog_en = 1'b1;
    rd0 = rd_cnt;
    for (int s = 0; s < NSYM; s++) begin
      chk($sformatf("b%02h_sym%0d_first", b, s), 32'(tif.serial_out), 32'(exp_sym(b, s)));
      repeat (SET - 1) @(negedge clk);
      chk($sformatf("b%02h_sym%0d_last", b, s), 32'(tif.serial_out), 32'(exp_sym(b, s)));
      @(negedge clk);
    end
    tog_en = 1'b0;
    chk("rd_in_frame", 32'(rd_cnt - rd0), 32'd0);
    chk("idle_after", 32'(tif.serial_out), 32'd1);
    chk("busy_after", 32'(tif.busy), 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    bit found;

    // Reset state, with fifo_rd_en held low while rst is high.
    repeat (3) @(negedge clk);
    chk("rst_serial", 32'(tif.serial_out), 32'd1);
    chk("rst_busy", 32'(tif.busy), 32'd0);
    chk("rst_rd_en", 32'(tif.fifo_rd_en), 32'd0);
    rst = 1'b0;

    // Empty FIFO for 1000 cycles: line idle, no pops.
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tif.serial_out !== 1'b1 || tif.busy !== 1'b0 || tif.fifo_rd_en !== 1'b0) bad++;
    end
    chk("idle_1000", 32'(bad), 32'd0);
    chk("idle_rd_cnt", 32'(rd_cnt), 32'd0);

    // Single byte 0x55; busy falls NSYM*SET+3 cycles after the pop cycle.
    push(8'h55);
    check_frame(8'h55, -1, 1'b0);
    chk("busy_fall_latency", 32'(cyc - rd_cyc), 32'(NSYM * SET + 3));
    chk("rd_cnt_55", 32'(rd_cnt), 32'd1);

    // Three queued bytes: exactly 3 idle cycles between frames.
    push(8'hA3);
    push(8'h0F);
    push(8'hFF);
    check_frame(8'hA3, -1, 1'b0);
    check_frame(8'h0F, 3, 1'b0);
    check_frame(8'hFF, 3, 1'b0);
    chk("rd_cnt_triple", 32'(rd_cnt), 32'd4);

    // Reset during data bit 4 of 0xC3, then 0x3C must follow intact (fifo_empty toggling).
    push(8'hC3);
    push(8'h3C);
    wait_start(n, found);
    repeat (5 * SET + 10) @(negedge clk);
    chk("c3_bit4", 32'(tif.serial_out), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_serial", 32'(tif.serial_out), 32'd1);
    chk("abort_busy", 32'(tif.busy), 32'd0);
    chk("abort_rd_en", 32'(tif.fifo_rd_en), 32'd0);
    rst = 1'b0;
    check_frame(8'h3C, 3, 1'b1);
    chk("rd_cnt_abort", 32'(rd_cnt), 32'd6);

`ifdef UART_FIFO_TX_PARITY_EN
    // 0x07 has odd weight -> parity 1; 0x03 even weight -> parity 0.
    chk("parity_07_ref", 32'(exp_sym(8'h07, 9)), 32'd1);
    chk("parity_03_ref", 32'(exp_sym(8'h03, 9)), 32'd0);
    push(8'h07);
    check_frame(8'h07, -1, 1'b0);
    chk("busy_fall_parity", 32'(cyc - rd_cyc), 32'(11 * SET + 3));
    push(8'h03);
    check_frame(8'h03, -1, 1'b0);
    chk("rd_cnt_parity", 32'(rd_cnt), 32'd8);
`endif

    repeat (20) @(negedge clk);
    chk("rd_protocol_viol", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 125_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 SHALL use derived constant SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division; 1085 at defaults); counter width = clog2(SYMBOL_EDGE_TIME).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port fifo_dout  input  8  byte at FIFO read head.
REQ-007 SHALL have port fifo_empty  input  1  FIFO holds no data.
REQ-008 SHALL have port fifo_rd_en  output  1  one-cycle pop request to the FIFO.
REQ-009 SHALL have port serial_out  output  1  UART TX line, idle high.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, POP, LOAD, START, DATA, PARITY (macro only), STOP.
REQ-012 IDLE: if fifo_empty==0, assert fifo_rd_en combinationally for that one cycle and go to POP; else stay.
REQ-013 fifo_rd_en SHALL be high only in IDLE with fifo_empty==0; never two consecutive cycles; never while fifo_empty==1.
REQ-014 POP: one wait cycle for the FIFO pointer update; go to LOAD.
REQ-015 LOAD: capture fifo_dout into an 8-bit shift register, clear baud and bit counters; go to START.
REQ-016 START: serial_out=0 for exactly SYMBOL_EDGE_TIME cycles, then DATA.
REQ-017 DATA: 8 bits LSB first, each held SYMBOL_EDGE_TIME cycles; bit counter 0..7; after bit 7 go to PARITY (macro) or STOP.
REQ-018 STOP: serial_out=1 for SYMBOL_EDGE_TIME cycles, then IDLE.
REQ-019 Baud counter SHALL count 0..SYMBOL_EDGE_TIME-1 and reset to 0 on every symbol boundary; no drift across frames.
REQ-020 Back-to-back: if FIFO non-empty on return to IDLE, next start bit SHALL begin exactly 3 cycles after the last stop-bit cycle (IDLE, POP, LOAD).
REQ-021 fifo_empty changes outside IDLE SHALL be ignored; a captured byte is always transmitted in full.
REQ-022 serial_out SHALL be registered (glitch-free); in IDLE, POP, LOAD it SHALL be 1.
REQ-023 Frame length SHALL be 10*SYMBOL_EDGE_TIME cycles without parity, 11*SYMBOL_EDGE_TIME with parity.

Reset
REQ-024 On rst high at a clock edge: state=IDLE, counters=0, shift register=0, serial_out=1, busy=0, fifo_rd_en=0 from next cycle.
REQ-025 Reset mid-frame SHALL abort the frame; the aborted byte is not retransmitted; transmission resumes from next FIFO entry after rst deasserts.
REQ-026 fifo_rd_en SHALL be 0 during any cycle rst is high.

Configuration
REQ-027 Macro UART_FIFO_TX_PARITY_EN defined: PARITY state inserted after DATA, serial_out = XOR of the 8 data bits (even parity) for SYMBOL_EDGE_TIME cycles, then STOP.
REQ-028 Macro undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Verification
REQ-029 Reset, FIFO empty 1000 cycles -> serial_out=1, busy=0, fifo_rd_en never asserted.
REQ-030 Push 0x55, defaults -> one rd_en pulse; line 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each 1085 cycles; busy low after 10850+3 cycles.
REQ-031 Push 0xA3,0x0F,0xFF together -> three frames in order, exactly 3 idle-high cycles between each stop bit and next start bit; exactly 3 rd_en pulses.
REQ-032 Assert rst during bit 4 of 0xC3 -> serial_out=1 next cycle, busy=0; next queued byte 0x3C sent as a complete, correct frame.
REQ-033 With UART_FIFO_TX_PARITY_EN, send 0x07 -> parity bit 1, frame 11*1085 cycles; 0x03 -> parity bit 0.
REQ-034 fifo_empty toggled randomly during a frame -> no rd_en pulses until frame ends; frame bits unchanged.
